// File: rtl/apb4_master_bridge.sv
// APB4 requester bridge.
// Accepts one valid/ready command at a time, runs it as an APB4 transfer on a
// multi-slave bus with address-decoded PSEL, and returns a valid/ready response
// carrying read data, slave error, timeout or decode-error status.
module apb4_master_bridge #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int NUM_SLV     = 4,
   parameter int SLV_AW      = 5,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETN,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [DATA_W-1:0]         cmd_wdata,
   input  logic [DATA_W/8-1:0]       cmd_strb,
   input  logic [2:0]                cmd_prot,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [ADDR_W-1:0]         PADDR,
   output logic                      PWRITE,
   output logic [DATA_W-1:0]         PWDATA,
   output logic [DATA_W/8-1:0]       PSTRB,
   output logic [2:0]                PPROT,
   output logic [NUM_SLV-1:0]        PSEL,
   output logic                      PENABLE,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR
);

   localparam int SEL_W = ADDR_W - SLV_AW;
   // Keep at least one counter bit so a disabled timeout still elaborates.
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   // The abort fires in the ACCESS cycle whose increment would reach the limit.
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SEL_W-1:0]    cmd_sel;
   logic [SEL_W-1:0]    sel_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic                cmd_hit;
   logic [NUM_SLV-1:0]  sel_onehot;
   logic                slv_ready;
   logic                slv_err;
   logic [DATA_W-1:0]   slv_rdata;
   logic                accept;
   logic                complete;
   logic                expire;

   assign cmd_sel = cmd_addr[ADDR_W-1:SLV_AW];

   // Address decode of the incoming command and return-path mux for the held slave.
   always_comb begin
      cmd_hit    = 1'b0;
      sel_onehot = '0;
      slv_ready  = 1'b0;
      slv_err    = 1'b0;
      slv_rdata  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (cmd_sel == SEL_W'(i)) begin
            cmd_hit = 1'b1;
         end
         if (sel_q == SEL_W'(i)) begin
            sel_onehot[i] = 1'b1;
            slv_ready     = PREADY[i];
            slv_err       = PSLVERR[i];
            slv_rdata     = PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   // Transfer state register.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the state-derived handshake and APB phase outputs.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      PSEL      = '0;
      PENABLE   = 1'b0;
      accept    = 1'b0;
      complete  = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = cmd_hit ? SETUP : RESP;
            end
         end
         SETUP: begin
            PSEL      = sel_onehot;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL    = sel_onehot;
            PENABLE = 1'b1;
            // A ready slave wins over a timeout landing in the same cycle.
            if (slv_ready) begin
               complete  = 1'b1;
               state_nxt = RESP;
            end else if ((TIMEOUT_CYC != 0) && (wait_cnt == CNT_LIMIT)) begin
               expire    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command capture: APB address/control/data stay frozen for the whole transfer.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PSTRB  <= '0;
         PPROT  <= '0;
         sel_q  <= '0;
      end else if (accept) begin
         PADDR  <= cmd_addr;
         PWRITE <= cmd_write;
         PWDATA <= cmd_write ? cmd_wdata : '0;
         PSTRB  <= cmd_write ? cmd_strb : '0;
         PPROT  <= cmd_prot;
         sel_q  <= cmd_sel;
      end
   end

   // Wait-state counter: cleared in SETUP, saturating count of ACCESS cycles without PREADY.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !slv_ready && (wait_cnt != '1)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Response fields: written once per transfer and left untouched after the handshake.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (accept && !cmd_hit) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b0;
      end else if (complete) begin
         rsp_rdata   <= PWRITE ? '0 : slv_rdata;
         rsp_err     <= slv_err;
         rsp_timeout <= 1'b0;
      end else if (expire) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b1;
      end
   end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- Parametrised APB4 requester that turns a valid/ready command stream into APB4 transfers on a multi-slave bus.
- Decodes upper address bits into one of NUM_SLV PSEL lines and muxes PRDATA, PREADY and PSLVERR back from the selected slave.
- Adds PSTRB/PPROT, wait-state handling, a per-transfer timeout and a decode-error response.
- Sits between testbench or CPU-side command sources and the peripheral APB fabric (e.g. SPI controller).

Parameters:
- ADDR_W, 16: PADDR width.
- DATA_W, 32: PWDATA/PRDATA width. Legal values: 8, 16, 32. STRB_W = DATA_W/8.
- NUM_SLV, 4: number of slaves / PSEL lines. Range 1..16.
- SLV_AW, 5: address bits per slave region. Slave index = addr[ADDR_W-1:SLV_AW]. Requires ADDR_W > SLV_AW.
- TIMEOUT_CYC, 16: maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  STRB_W  write byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  PSLVERR, timeout or decode error.
- rsp_timeout  out  1  error was a timeout.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  STRB_W  APB write strobes.
- PPROT  out  3  APB protection.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PRDATA  in  NUM_SLV*DATA_W  packed read data; slave i occupies [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

Behaviour:
- Reset values:
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - State IDLE, so cmd_ready=1 once reset is released.
- States: IDLE, SETUP, ACCESS, RESP. cmd_ready=1 only in IDLE.
- IDLE:
  - On cmd_valid&cmd_ready, register addr/write/wdata/strb/prot.
  - Compute sel from the registered address.
  - If sel >= NUM_SLV: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No PSEL is asserted.
  - Otherwise go to SETUP.
- SETUP (one cycle):
  - PSEL[sel]=1, PENABLE=0.
  - PADDR/PWRITE/PPROT driven from the registered command.
  - PWDATA/PSTRB from the command for writes. Reads drive PSTRB=0 and PWDATA=0.
  - Next state ACCESS; wait counter cleared.
- ACCESS:
  - PSEL held, PENABLE=1. All address/control/data outputs are stable for the whole access.
  - If PREADY[sel]=1 at a PCLK edge:
    - Capture PRDATA slice (reads only) and PSLVERR[sel] into rsp_rdata/rsp_err.
    - Drop PSEL/PENABLE the next cycle and go to RESP.
  - Otherwise increment the wait counter.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC:
    - Abort: PSEL/PENABLE drop next cycle.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
  - PREADY arriving in the same cycle the counter hits the limit counts as a completion, not a timeout.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: go to IDLE next cycle and clear rsp_valid.
  - rsp_* fields keep their last values after the handshake.
- Latency:
  - Zero-wait transfer: accept at edge 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Each wait state adds one cycle.
  - Decode error: rsp_valid in the cycle after acceptance.
- PREADY/PSLVERR/PRDATA of non-selected slaves are ignored in every state.
- PSLVERR is sampled only in the completing ACCESS cycle. A read with PSLVERR still returns the slice in rsp_rdata.
- Wait counter width = $clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- Reset asserted mid-transfer: all outputs go to reset values asynchronously. The in-flight command is dropped and no response is issued.
- Only one transfer is outstanding at a time. A command presented while not IDLE is held off by cmd_ready=0.

Test Plan:
- Write addr 0x0004, wdata 0xA5A5_1234, strb 0xF, slave 0 PREADY tied high -> PSEL=0001 for 2 cycles, PENABLE high in the 2nd, PSTRB=F, rsp_valid at cycle 3, rsp_err=0.
- Read addr 0x0048 (slave 2), slave asserts PREADY after 3 wait cycles, PRDATA slice=0xDEAD_BEEF -> PSEL=0100, ACCESS lasts 4 cycles, rsp_rdata=0xDEADBEEF, PSTRB=0 throughout.
- Write to slave 1 with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0.
- Read slave 3 with PREADY held low, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0.
- Address 0x00A0 (sel=5 >= NUM_SLV=4) -> no PSEL activity, rsp_valid next cycle with rsp_err=1; rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready=0 until the handshake.
- Assert PRESETN low during ACCESS -> PSEL/PENABLE/rsp_valid=0 immediately; after release cmd_ready=1 and the next transfer completes normally.
